// File: rtl/clock_pkg.sv
// Shared types, constants and BCD validation for the multi-alarm clock.
// Time words pack BCD digits as {hour_shi, hour_ge, min_shi, min_ge, sec_shi, sec_ge}.
package clock_pkg;

  typedef logic [3:0]  bcd_t;
  typedef logic [23:0] hms_t;
  typedef logic [15:0] hm_t;

  localparam int         SEC_PER_MIN = 60;
  localparam logic [7:0] HOUR_MAX    = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RING,
    ST_SNOOZE
  } ring_state_t;

  function automatic logic bcd_time_valid(input hms_t t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (t[15:12] > 4'd5) ok = 1'b0;
    if (t[7:4] > 4'd5) ok = 1'b0;
    // With every digit already <= 9, a raw compare orders BCD hours.
    if (t[23:16] > HOUR_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Seconds prescaler and BCD 24-hour carry chain with validated load.
// min_rollover_o pulses the cycle after a tick that rolled seconds to 00.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  hms_t load_val_i,
  output hms_t time_o,
  output logic sec_tick_o,
  output logic min_rollover_o,
  output logic load_err_o
);

  localparam int PW = $clog2(CLK_HZ);

  logic [PW-1:0] presc_q;
  hms_t          time_q;
  logic          roll_q;
  logic          load_ok;

  function automatic hms_t hms_inc(input hms_t t);
    hms_t n;
    n = t;
    if (t[3:0] != 4'd9) begin
      n[3:0] = t[3:0] + 4'd1;
    end else begin
      n[3:0] = '0;
      if (t[7:4] != 4'd5) begin
        n[7:4] = t[7:4] + 4'd1;
      end else begin
        n[7:4] = '0;
        if (t[11:8] != 4'd9) begin
          n[11:8] = t[11:8] + 4'd1;
        end else begin
          n[11:8] = '0;
          if (t[15:12] != 4'd5) begin
            n[15:12] = t[15:12] + 4'd1;
          end else begin
            n[15:12] = '0;
            if (t[23:16] == HOUR_MAX) begin
              n[23:16] = '0;
            end else if (t[19:16] == 4'd9) begin
              n[19:16] = '0;
              n[23:20] = t[23:20] + 4'd1;
            end else begin
              n[19:16] = t[19:16] + 4'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  assign load_ok        = bcd_time_valid(load_val_i);
  assign load_err_o     = load_i && !load_ok;
  assign sec_tick_o     = (presc_q == PW'(CLK_HZ - 1));
  assign time_o         = time_q;
  assign min_rollover_o = roll_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      time_q  <= '0;
      roll_q  <= 1'b0;
    end else begin
      roll_q <= 1'b0;
      if (load_i && load_ok) begin
        presc_q <= '0;
        time_q  <= load_val_i;
      end else if (sec_tick_o) begin
        presc_q <= '0;
        time_q  <= hms_inc(time_q);
        roll_q  <= (time_q[7:0] == 8'h59);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// BCD clock with N alarm slots, shared ring/snooze control and
// optional 12-hour display conversion.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int N_ALARM    = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int IDXW       = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_time_finish,
  input  logic [23:0]        set_time,
  input  logic               alm_wr,
  input  logic [IDXW-1:0]    alm_idx,
  input  logic [15:0]        alm_time,
  input  logic               alm_en_in,
  input  logic               snooze,
  input  logic               stop,
  input  logic               mode_12h,
  output logic [23:0]        time_bcd,
  output logic               pm,
  output logic               sec_tick,
  output logic               clock_out,
  output logic [IDXW-1:0]    ring_idx,
  output logic [N_ALARM-1:0] alm_en,
  output logic               set_err
);

  localparam int CW      = 12;
  localparam int SNZ_SEC = SNOOZE_MIN * SEC_PER_MIN;

  hms_t               cur_time;
  logic               tick;
  logic               roll;
  logic               load_err;
  hm_t                alm_q [N_ALARM];
  logic [N_ALARM-1:0] alm_en_q;
  logic               alm_ok;
  logic               hit;
  logic [IDXW-1:0]    hit_idx;
  logic               match;
  logic               ring_en;
  ring_state_t        state_q;
  logic [CW-1:0]      cnt_q;
  logic [IDXW-1:0]    ring_idx_q;
  logic               clock_out_q;
  logic [4:0]         hbin;
  logic [7:0]         disp_hour;
  logic               disp_pm;
  logic [23:0]        time_bcd_q;
  logic               pm_q;
  logic               set_err_q;

  bcd_time_counter #(
    .CLK_HZ(CLK_HZ)
  ) u_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (set_time_finish),
    .load_val_i    (set_time),
    .time_o        (cur_time),
    .sec_tick_o    (tick),
    .min_rollover_o(roll),
    .load_err_o    (load_err)
  );

  assign alm_ok = bcd_time_valid({alm_time, 8'h00});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alm_en_q <= '0;
      for (int i = 0; i < N_ALARM; i++) alm_q[i] <= '0;
    end else if (alm_wr && alm_ok) begin
      for (int i = 0; i < N_ALARM; i++) begin
        if (alm_idx == IDXW'(i)) begin
          alm_q[i]    <= alm_time;
          alm_en_q[i] <= alm_en_in;
        end
      end
    end
  end

  // Scan downward so the lowest matching slot is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (alm_en_q[i] && alm_q[i] == cur_time[23:8]) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  assign match = roll && hit;

  always_comb begin
    ring_en = 1'b0;
    for (int i = 0; i < N_ALARM; i++) begin
      if (ring_idx_q == IDXW'(i)) ring_en = alm_en_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ring_idx_q  <= '0;
      clock_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_q     <= ST_RING;
            ring_idx_q  <= hit_idx;
            cnt_q       <= '0;
            clock_out_q <= 1'b1;
          end
        end
        ST_RING: begin
          if (stop || !ring_en) begin
            state_q     <= ST_IDLE;
            clock_out_q <= 1'b0;
          end else if (snooze) begin
            state_q     <= ST_SNOOZE;
            cnt_q       <= CW'(SNZ_SEC);
            clock_out_q <= 1'b0;
          end else if (tick) begin
            if (cnt_q == CW'(RING_SEC - 1)) begin
              state_q     <= ST_IDLE;
              clock_out_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            state_q     <= ST_IDLE;
            clock_out_q <= 1'b0;
          end else if (match) begin
            state_q     <= ST_RING;
            ring_idx_q  <= hit_idx;
            cnt_q       <= '0;
            clock_out_q <= 1'b1;
          end else if (!ring_en) begin
            state_q     <= ST_IDLE;
            clock_out_q <= 1'b0;
          end else if (tick) begin
            if (cnt_q == CW'(1)) begin
              state_q     <= ST_RING;
              cnt_q       <= '0;
              clock_out_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          clock_out_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hbin      = 5'(cur_time[23:20]) * 5'd10 + 5'(cur_time[19:16]);
    disp_pm   = 1'b0;
    disp_hour = cur_time[23:16];
    if (mode_12h) begin
      if (hbin >= 5'd12) disp_pm = 1'b1;
      if (hbin > 5'd12) hbin = hbin - 5'd12;
      else if (hbin == 5'd0) hbin = 5'd12;
      disp_hour = (hbin >= 5'd10) ? {4'd1, 4'(hbin - 5'd10)}
                                  : {4'd0, hbin[3:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      time_bcd_q <= '0;
      pm_q       <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      time_bcd_q <= {disp_hour, cur_time[15:0]};
      pm_q       <= disp_pm;
      set_err_q  <= load_err || (alm_wr && !alm_ok);
    end
  end

  assign time_bcd  = time_bcd_q;
  assign pm        = pm_q;
  assign sec_tick  = tick;
  assign clock_out = clock_out_q;
  assign ring_idx  = ring_idx_q;
  assign alm_en    = alm_en_q;
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scenario bench for multi_alarm_clock with a fast prescaler.
// Expected display words and ring slots flow through scoreboard queues.
module tb_multi_alarm_clock;

  localparam int CLK_HZ     = 4;
  localparam int N_ALARM    = 4;
  localparam int SNOOZE_MIN = 1;
  localparam int RING_SEC   = 5;
  localparam int IDXW       = 2;
  localparam int SNZ_TICKS  = SNOOZE_MIN * 60;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               set_time_finish = 1'b0;
  logic [23:0]        set_time = '0;
  logic               alm_wr = 1'b0;
  logic [IDXW-1:0]    alm_idx = '0;
  logic [15:0]        alm_time = '0;
  logic               alm_en_in = 1'b0;
  logic               snooze = 1'b0;
  logic               stop = 1'b0;
  logic               mode_12h = 1'b0;
  logic [23:0]        time_bcd;
  logic               pm;
  logic               sec_tick;
  logic               clock_out;
  logic [IDXW-1:0]    ring_idx;
  logic [N_ALARM-1:0] alm_en;
  logic               set_err;

  int n_chk = 0;
  int n_pass = 0;

  logic [24:0]     disp_q[$];
  logic [IDXW-1:0] ring_q[$];

  multi_alarm_clock #(
    .CLK_HZ    (CLK_HZ),
    .N_ALARM   (N_ALARM),
    .SNOOZE_MIN(SNOOZE_MIN),
    .RING_SEC  (RING_SEC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_time_finish(set_time_finish),
    .set_time       (set_time),
    .alm_wr         (alm_wr),
    .alm_idx        (alm_idx),
    .alm_time       (alm_time),
    .alm_en_in      (alm_en_in),
    .snooze         (snooze),
    .stop           (stop),
    .mode_12h       (mode_12h),
    .time_bcd       (time_bcd),
    .pm             (pm),
    .sec_tick       (sec_tick),
    .clock_out      (clock_out),
    .ring_idx       (ring_idx),
    .alm_en         (alm_en),
    .set_err        (set_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick_wait();
    for (int i = 0; i < 4 * CLK_HZ; i++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) return;
    end
    n_chk++;
    $display("FAIL tick_timeout: got no sec_tick want one within %0d cycles",
             4 * CLK_HZ);
  endtask

  task automatic load(input logic [23:0] v);
    set_time        = v;
    set_time_finish = 1'b1;
    @(negedge clk);
    set_time_finish = 1'b0;
  endtask

  task automatic wr_alm(input int idx, input logic [15:0] t, input logic en);
    alm_idx   = IDXW'(idx);
    alm_time  = t;
    alm_en_in = en;
    alm_wr    = 1'b1;
    @(negedge clk);
    alm_wr = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic z);
    stop   = s;
    snooze = z;
    @(negedge clk);
    stop   = 1'b0;
    snooze = 1'b0;
  endtask

  task automatic ring_at(input logic [23:0] t);
    load(t);
    tick_wait();
    tick_wait();
    @(negedge clk);
    n_chk++;
    if (clock_out !== 1'b0)
      $display("FAIL ring_early: got clock_out=%b want 0", clock_out);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int c;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({pm, time_bcd} !== 25'h0)
      $display("FAIL rst_time: got %h want 0", {pm, time_bcd});
    else n_pass++;
    n_chk++;
    if ({sec_tick, clock_out, set_err, ring_idx, alm_en} !== '0)
      $display("FAIL rst_ctrl: got %b want 0",
               {sec_tick, clock_out, set_err, ring_idx, alm_en});
    else n_pass++;
    rst_n = 1'b1;
    tick_wait();
    for (int k = 0; k < 2; k++) begin
      c = 0;
      for (int i = 1; i <= 4 * CLK_HZ; i++) begin
        @(negedge clk);
        if (sec_tick === 1'b1) begin
          c = i;
          break;
        end
      end
      n_chk++;
      if (c != CLK_HZ)
        $display("FAIL tick_period: got %0d want %0d", c, CLK_HZ);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [24:0] e;
    mode_12h = 1'b0;
    load(24'h235958);
    n_chk++;
    if (set_err !== 1'b0)
      $display("FAIL wrap_err: got %b want 0", set_err);
    else n_pass++;
    disp_q.push_back({1'b0, 24'h235958});
    @(negedge clk);
    e = disp_q.pop_front();
    n_chk++;
    if ({pm, time_bcd} !== e)
      $display("FAIL wrap_load: got %h want %h", {pm, time_bcd}, e);
    else n_pass++;
    tick_wait();
    tick_wait();
    disp_q.push_back({1'b0, 24'h000000});
    repeat (2) @(negedge clk);
    e = disp_q.pop_front();
    n_chk++;
    if ({pm, time_bcd} !== e)
      $display("FAIL wrap_mid: got %h want %h", {pm, time_bcd}, e);
    else n_pass++;
  endtask

  task automatic test_load_err();
    logic [24:0] e;
    load(24'h101010);
    load(24'h240000);
    disp_q.push_back({1'b0, 24'h101010});
    e = disp_q.pop_front();
    n_chk++;
    if ({set_err, pm, time_bcd} !== {1'b1, e})
      $display("FAIL err_hour: got %h want %h", {set_err, pm, time_bcd},
               {1'b1, e});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (set_err !== 1'b0)
      $display("FAIL err_width: got %b want 0", set_err);
    else n_pass++;
    load(24'h126000);
    disp_q.push_back({1'b0, 24'h101010});
    e = disp_q.pop_front();
    n_chk++;
    if ({set_err, pm, time_bcd} !== {1'b1, e})
      $display("FAIL err_min: got %h want %h", {set_err, pm, time_bcd},
               {1'b1, e});
    else n_pass++;
    tick_wait();
    load(24'h050505);
    disp_q.push_back({1'b0, 24'h050505});
    @(negedge clk);
    e = disp_q.pop_front();
    n_chk++;
    if ({pm, time_bcd} !== e)
      $display("FAIL load_vs_tick: got %h want %h", {pm, time_bcd}, e);
    else n_pass++;
    tick_wait();
    disp_q.push_back({1'b0, 24'h050506});
    repeat (2) @(negedge clk);
    e = disp_q.pop_front();
    n_chk++;
    if ({pm, time_bcd} !== e)
      $display("FAIL after_load_tick: got %h want %h", {pm, time_bcd}, e);
    else n_pass++;
  endtask

  task automatic test_alarm();
    logic [IDXW-1:0] r;
    wr_alm(2, 16'h1260, 1'b1);
    n_chk++;
    if ({set_err, alm_en} !== 5'b1_0000)
      $display("FAIL alm_bad: got %b want 10000", {set_err, alm_en});
    else n_pass++;
    wr_alm(1, 16'h0700, 1'b1);
    wr_alm(2, 16'h0700, 1'b1);
    n_chk++;
    if ({set_err, alm_en} !== 5'b0_0110)
      $display("FAIL alm_en: got %b want 00110", {set_err, alm_en});
    else n_pass++;
    ring_q.push_back(IDXW'(1));
    ring_at(24'h065958);
    r = ring_q.pop_front();
    n_chk++;
    if ({clock_out, ring_idx} !== {1'b1, r})
      $display("FAIL ring_prio: got %b want %b", {clock_out, ring_idx},
               {1'b1, r});
    else n_pass++;
    repeat (RING_SEC - 1) tick_wait();
    @(negedge clk);
    n_chk++;
    if (clock_out !== 1'b1)
      $display("FAIL ring_hold: got %b want 1", clock_out);
    else n_pass++;
    tick_wait();
    @(negedge clk);
    n_chk++;
    if (clock_out !== 1'b0)
      $display("FAIL auto_off: got %b want 0", clock_out);
    else n_pass++;
  endtask

  task automatic test_snooze();
    logic [IDXW-1:0] r;
    ring_at(24'h065958);
    pulse(1'b0, 1'b1);
    n_chk++;
    if (clock_out !== 1'b0)
      $display("FAIL snooze_off: got %b want 0", clock_out);
    else n_pass++;
    repeat (SNZ_TICKS - 1) tick_wait();
    @(negedge clk);
    n_chk++;
    if (clock_out !== 1'b0)
      $display("FAIL snooze_early: got %b want 0", clock_out);
    else n_pass++;
    ring_q.push_back(IDXW'(1));
    tick_wait();
    @(negedge clk);
    r = ring_q.pop_front();
    n_chk++;
    if ({clock_out, ring_idx} !== {1'b1, r})
      $display("FAIL snooze_wake: got %b want %b", {clock_out, ring_idx},
               {1'b1, r});
    else n_pass++;
    pulse(1'b1, 1'b1);
    n_chk++;
    if (clock_out !== 1'b0)
      $display("FAIL stop_snooze: got %b want 0", clock_out);
    else n_pass++;
    repeat (SNZ_TICKS + 2) tick_wait();
    @(negedge clk);
    n_chk++;
    if (clock_out !== 1'b0)
      $display("FAIL stop_wins: got %b want 0", clock_out);
    else n_pass++;
  endtask

  task automatic test_preempt();
    logic [IDXW-1:0] r;
    wr_alm(0, 16'h0800, 1'b1);
    wr_alm(3, 16'h0801, 1'b1);
    ring_q.push_back(IDXW'(0));
    ring_at(24'h075958);
    r = ring_q.pop_front();
    n_chk++;
    if ({clock_out, ring_idx} !== {1'b1, r})
      $display("FAIL ring_slot0: got %b want %b", {clock_out, ring_idx},
               {1'b1, r});
    else n_pass++;
    pulse(1'b0, 1'b1);
    ring_q.push_back(IDXW'(3));
    ring_at(24'h080058);
    r = ring_q.pop_front();
    n_chk++;
    if ({clock_out, ring_idx} !== {1'b1, r})
      $display("FAIL preempt: got %b want %b", {clock_out, ring_idx},
               {1'b1, r});
    else n_pass++;
    wr_alm(3, 16'h0801, 1'b0);
    n_chk++;
    if (alm_en !== 4'b0111)
      $display("FAIL disable_en: got %b want 0111", alm_en);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (clock_out !== 1'b0)
      $display("FAIL disable_idle: got %b want 0", clock_out);
    else n_pass++;
  endtask

  task automatic test_reset_ring();
    logic [IDXW-1:0] r;
    ring_q.push_back(IDXW'(1));
    ring_at(24'h065958);
    r = ring_q.pop_front();
    n_chk++;
    if ({clock_out, ring_idx} !== {1'b1, r})
      $display("FAIL ring_pre_rst: got %b want %b", {clock_out, ring_idx},
               {1'b1, r});
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({clock_out, ring_idx, alm_en, set_err, sec_tick, pm, time_bcd} !== '0)
      $display("FAIL rst_mid_ring: got %h want 0",
               {clock_out, ring_idx, alm_en, set_err, sec_tick, pm, time_bcd});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_12h();
    logic [23:0] ld [6];
    logic [24:0] ex [6];
    logic [24:0] e;
    ld = '{24'h001500, 24'h120000, 24'h235900,
           24'h133000, 24'h091000, 24'h235900};
    ex = '{{1'b0, 24'h121500}, {1'b1, 24'h120000}, {1'b1, 24'h115900},
           {1'b1, 24'h013000}, {1'b0, 24'h091000}, {1'b0, 24'h235900}};
    for (int i = 0; i < 6; i++) begin
      mode_12h = (i < 5);
      load(ld[i]);
      disp_q.push_back(ex[i]);
      @(negedge clk);
      e = disp_q.pop_front();
      n_chk++;
      if ({pm, time_bcd} !== e)
        $display("FAIL fmt12_%0d: got %h want %h", i, {pm, time_bcd}, e);
      else n_pass++;
    end
    mode_12h = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_load_err();
    test_alarm();
    test_snooze();
    test_preempt();
    test_reset_ring();
    test_12h();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
